// File: rtl/uart_rx.sv
// Oversampling UART receiver: two-flop input synchroniser, start-bit
// validation, 3-sample majority vote at mid-bit, LSB-first data assembly
// and stop-bit check with one-cycle ready / framing-error pulses.
//
// state     | meaning
// ----------+---------------------------------------------------------------
// WAIT_IDLE | line must be seen high before a start edge is accepted
// IDLE      | line idle, waiting for a low sample on a tick
// START     | validating the start bit; a high mid-bit vote is a glitch
// DATA      | sampling data bits, LSB first
// STOP      | checking the stop bit, then report byte or framing error
module uart_rx #(
    parameter int DATA_BITS  = 8,
    parameter int OVERSAMPLE = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 bclk,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] dout,
    output logic                 dout_rdy,
    output logic                 frame_err,
    output logic                 busy
);

    localparam int TW  = $clog2(OVERSAMPLE);
    localparam int BW  = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
    localparam int MID = OVERSAMPLE / 2 - 1;

    localparam logic [TW-1:0] T_PRE  = TW'(MID - 1);
    localparam logic [TW-1:0] T_MID  = TW'(MID);
    localparam logic [TW-1:0] T_VOTE = TW'(MID + 1);
    localparam logic [TW-1:0] T_LAST = TW'(OVERSAMPLE - 1);
    localparam logic [BW-1:0] B_LAST = BW'(DATA_BITS - 1);

    typedef enum logic [2:0] {
        WAIT_IDLE,
        IDLE,
        START,
        DATA,
        STOP
    } state_t;

    state_t                 state;
    logic                   rx_meta;
    logic                   rxs;
    logic [TW-1:0]          tcnt;
    logic [BW-1:0]          bcnt;
    logic [DATA_BITS-1:0]   shreg;
    logic                   samp_a;
    logic                   samp_b;
    logic                   vote;

    // Majority of the two earlier mid-bit samples and the current one.
    assign vote = (samp_a & samp_b) | (samp_a & rxs) | (samp_b & rxs);

    // Two-flop synchroniser for the asynchronous rx pin; idles high.
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_meta <= 1'b1;
            rxs     <= 1'b1;
        end else begin
            rx_meta <= rx;
            rxs     <= rxs == rxs ? rx_meta : rx_meta;
        end
    end

    // Receive FSM; everything except the output pulses advances only on bclk.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= WAIT_IDLE;
            tcnt      <= '0;
            bcnt      <= '0;
            shreg     <= '0;
            samp_a    <= 1'b1;
            samp_b    <= 1'b1;
            dout      <= '0;
            dout_rdy  <= 1'b0;
            frame_err <= 1'b0;
            busy      <= 1'b0;
        end else begin
            dout_rdy  <= 1'b0;
            frame_err <= 1'b0;
            if (bclk) begin
                if (tcnt == T_PRE) samp_a <= rxs;
                if (tcnt == T_MID) samp_b <= rxs;
                case (state)
                    WAIT_IDLE: begin
                        if (rxs) state <= IDLE;
                    end
                    IDLE: begin
                        if (!rxs) begin
                            state <= START;
                            tcnt  <= '0;
                            busy  <= 1'b1;
                        end
                    end
                    START: begin
                        // The start bit runs its full period so that every
                        // later bit is sampled at the same offset from its edge.
                        if (tcnt == T_VOTE && vote) begin
                            state <= IDLE;
                            tcnt  <= '0;
                            busy  <= 1'b0;
                        end else if (tcnt == T_LAST) begin
                            state <= DATA;
                            tcnt  <= '0;
                            bcnt  <= '0;
                        end else begin
                            tcnt <= tcnt + 1'b1;
                        end
                    end
                    DATA: begin
                        if (tcnt == T_VOTE) shreg[bcnt] <= vote;
                        if (tcnt == T_LAST) begin
                            tcnt <= '0;
                            if (bcnt == B_LAST) state <= STOP;
                            else                bcnt  <= bcnt + 1'b1;
                        end else begin
                            tcnt <= tcnt + 1'b1;
                        end
                    end
                    STOP: begin
                        // Leaving at mid-stop lets the next start edge resync.
                        if (tcnt == T_VOTE) begin
                            tcnt <= '0;
                            busy <= 1'b0;
                            if (vote) begin
                                dout     <= shreg;
                                dout_rdy <= 1'b1;
                                state    <= IDLE;
                            end else begin
                                frame_err <= 1'b1;
                                state     <= WAIT_IDLE;
                            end
                        end else begin
                            tcnt <= tcnt + 1'b1;
                        end
                    end
                    default: state <= WAIT_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: table of clean frames plus hand-written
// glitch, framing-error/break, and mid-frame reset sequences.
module tb_uart_rx;

    logic       clk;
    logic       rst;
    logic       bclk;
    logic       rx;
    logic [7:0] dout;
    logic       dout_rdy;
    logic       frame_err;
    logic       busy;

    int checks = 0;
    int errors = 0;

    // Tick bookkeeping, updated 1 ns after the posedge that raises bclk.
    int gtick = 0;
    int div   = 0;
    int tx_start_gtick = 0;

    // Monitor counters, sampled on the falling edge.
    int  rdy_pulses = 0, rdy_cycles = 0;
    int  err_pulses = 0, err_cycles = 0;
    int  busy_cycles = 0, overlap = 0;
    int  last_rdy_gtick = 0, last_err_gtick = 0;
    logic rdy_q = 1'b0, err_q = 1'b0;

    uart_rx dut (
        .clk       (clk),
        .rst       (rst),
        .bclk      (bclk),
        .rx        (rx),
        .dout      (dout),
        .dout_rdy  (dout_rdy),
        .frame_err (frame_err),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // bclk: one clk-wide pulse every 4 clk.
    initial begin
        bclk = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            div  = (div == 3) ? 0 : div + 1;
            bclk = (div == 0);
            if (bclk) gtick = gtick + 1;
        end
    end

    // Output monitor: pulse counts, pulse widths, overlap and busy time.
    always @(negedge clk) begin
        rdy_q <= dout_rdy;
        err_q <= frame_err;
        if (dout_rdy) rdy_cycles <= rdy_cycles + 1;
        if (frame_err) err_cycles <= err_cycles + 1;
        if (dout_rdy && !rdy_q) begin
            rdy_pulses     <= rdy_pulses + 1;
            last_rdy_gtick <= gtick;
        end
        if (frame_err && !err_q) begin
            err_pulses     <= err_pulses + 1;
            last_err_gtick <= gtick;
        end
        if (dout_rdy && frame_err) overlap <= overlap + 1;
        if (busy) busy_cycles <= busy_cycles + 1;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input int actual, input int expected);
        checks = checks + 1;
        if (actual !== expected) begin
            errors = errors + 1;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)",
                     name, actual, actual, expected, expected);
        end
    endtask

    task automatic wait_tick();
        do @(negedge clk); while (!bclk);
    endtask

    task automatic idle_ticks(input logic level, input int n);
        rx = level;
        for (int i = 0; i < n; i++) wait_tick();
    endtask

    // Drive one 8N1 frame, one tick per oversample slot; stops after max_ticks.
    // A spike inverts the line for the single tick M (7) of every data bit.
    task automatic send_frame(input logic [7:0] data, input logic stop_bit,
                              input logic spike, input int max_ticks);
        logic v;
        int   b, t;
        for (int idx = 0; idx < 160 && idx < max_ticks; idx++) begin
            b = idx / 16;
            t = idx % 16;
            if (b == 0)      v = 1'b0;
            else if (b <= 8) v = data[b-1];
            else             v = stop_bit;
            if (spike && b >= 1 && b <= 8 && t == 7) v = ~v;
            rx = v;
            if (idx == 0) tx_start_gtick = gtick;
            wait_tick();
        end
    endtask

    typedef struct {
        logic [7:0] data;
        logic       spike;
        int         gap;
        logic [7:0] exp_dout;
    } vec_t;

    vec_t vecs[5];

    int rdy0, err0, busy0;

    initial begin
        // Clean frames: 612 = 153 ticks x 4 clk of busy; pulse 1 + 153 ticks
        // after the tick preceding the start-bit drive.
        vecs[0] = '{data: 8'hA5, spike: 1'b0, gap: 4, exp_dout: 8'hA5};
        vecs[1] = '{data: 8'h00, spike: 1'b0, gap: 0, exp_dout: 8'h00};
        vecs[2] = '{data: 8'hFF, spike: 1'b0, gap: 0, exp_dout: 8'hFF};
        vecs[3] = '{data: 8'h3C, spike: 1'b0, gap: 0, exp_dout: 8'h3C};
        vecs[4] = '{data: 8'h96, spike: 1'b1, gap: 4, exp_dout: 8'h96};

        rst = 1'b1;
        rx  = 1'b1;
        repeat (4) @(negedge clk);
        check("reset_dout", int'(dout), 0);
        check("reset_rdy", int'(dout_rdy), 0);
        check("reset_err", int'(frame_err), 0);
        check("reset_busy", int'(busy), 0);
        rst = 1'b0;
        idle_ticks(1'b1, 3);

        for (int i = 0; i < 5; i++) begin
            rdy0  = rdy_pulses;
            err0  = err_pulses;
            busy0 = busy_cycles;
            idle_ticks(1'b1, vecs[i].gap);
            send_frame(vecs[i].data, 1'b1, vecs[i].spike, 160);
            check("vec_rdy_count", rdy_pulses - rdy0, 1);
            check("vec_err_count", err_pulses - err0, 0);
            check("vec_dout", int'(dout), int'(vecs[i].exp_dout));
            check("vec_busy_len", busy_cycles - busy0, 612);
            check("vec_latency", last_rdy_gtick - tx_start_gtick, 154);
            check("vec_busy_end", int'(busy), 0);
        end

        // 3-tick low glitch on an idle line: start is rejected at mid-bit.
        rdy0 = rdy_pulses;
        err0 = err_pulses;
        send_frame(8'hFF, 1'b1, 1'b0, 3);
        idle_ticks(1'b1, 2);
        check("glitch_busy_rise", int'(busy), 1);
        idle_ticks(1'b1, 20);
        check("glitch_busy_fall", int'(busy), 0);
        check("glitch_no_rdy", rdy_pulses - rdy0, 0);
        check("glitch_no_err", err_pulses - err0, 0);
        check("glitch_dout_held", int'(dout), 'h96);
        send_frame(8'h5A, 1'b1, 1'b0, 160);
        check("after_glitch_rdy", rdy_pulses - rdy0, 1);
        check("after_glitch_dout", int'(dout), 'h5A);

        // Stop bit low, then a 40-tick break, then a good frame.
        idle_ticks(1'b1, 4);
        rdy0 = rdy_pulses;
        err0 = err_pulses;
        send_frame(8'h81, 1'b0, 1'b0, 160);
        check("ferr_err_count", err_pulses - err0, 1);
        check("ferr_no_rdy", rdy_pulses - rdy0, 0);
        check("ferr_dout_held", int'(dout), 'h5A);
        check("ferr_latency", last_err_gtick - tx_start_gtick, 154);
        busy0 = busy_cycles;
        idle_ticks(1'b0, 40);
        check("break_no_busy", busy_cycles - busy0, 0);
        check("break_no_err", err_pulses - err0, 1);
        check("break_no_rdy", rdy_pulses - rdy0, 0);
        idle_ticks(1'b1, 4);
        send_frame(8'h42, 1'b1, 1'b0, 160);
        check("after_break_rdy", rdy_pulses - rdy0, 1);
        check("after_break_dout", int'(dout), 'h42);

        // Reset pulse in the middle of bit 4 of 0xC3.
        idle_ticks(1'b1, 4);
        rdy0 = rdy_pulses;
        err0 = err_pulses;
        send_frame(8'hC3, 1'b1, 1'b0, 16 * 5 + 8);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        rx  = 1'b1;
        check("midrst_dout", int'(dout), 0);
        check("midrst_busy", int'(busy), 0);
        check("midrst_rdy", int'(dout_rdy), 0);
        check("midrst_err", int'(frame_err), 0);
        idle_ticks(1'b1, 20);
        check("midrst_no_rdy", rdy_pulses - rdy0, 0);
        check("midrst_no_err", err_pulses - err0, 0);
        send_frame(8'h24, 1'b1, 1'b0, 160);
        check("after_rst_rdy", rdy_pulses - rdy0, 1);
        check("after_rst_dout", int'(dout), 'h24);
        idle_ticks(1'b1, 2);

        check("rdy_single_cycle", rdy_cycles, rdy_pulses);
        check("err_single_cycle", err_cycles, err_pulses);
        check("rdy_err_overlap", overlap, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
